// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX hazard inputs and stage-register controls.
// Latency: pure wiring; the controller drives its outputs combinationally from state plus inputs.
// Backpressure: none on the bundle itself; stalls are expressed through the write-enable signals.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W   = 32,
  parameter int FLUSH_W = 16
);
  // hazard sources from the pipeline
  logic [4:0]         ifid_rs;
  logic [4:0]         ifid_rt;
  logic               ifid_uses_rt;
  logic               idex_mem_read;
  logic [4:0]         idex_rt;
  logic               mc_start;
  logic               branch_taken;
  // stage-register controls back to the pipeline
  logic               pc_write;
  logic               ifid_write;
  logic               ifid_flush;
  logic               idex_write;
  logic               idex_flush;
  logic               exmem_flush;
  logic               mc_done;
  logic               busy;
  logic [CNT_W-1:0]   stall_cycles;
  logic [FLUSH_W-1:0] flush_count;

  // pipeline side
  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_rt, mc_start, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush,
    input  mc_done, busy, stall_cycles, flush_count
  );

  // controller side
  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_rt, mc_start, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush,
    output mc_done, busy, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencing for IF/ID, ID/EX, EX/MEM: load-use bubble, branch squash, multi-cycle EX hold.
// Latency: controls are Mealy (same cycle as the hazard); perf counters update on the following edge.
// Backpressure: a multi-cycle EX op freezes PC/IF/ID/ID-EX for MC_LATENCY-1 cycles; load-use stalls one cycle.
module hazard_stall_ctrl #(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32,
  parameter int FLUSH_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  hazard_stall_ctrl_if.slave bus
);

  localparam int CW = $clog2(MC_LATENCY) + 1;
  localparam bit MC_STALLS = (MC_LATENCY > 1);
  // the first hold cycle happens in RUN, so the wait state only needs to cover the remainder
  localparam logic [CW-1:0] RELOAD = MC_STALLS ? CW'(MC_LATENCY - 2) : '0;

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      count, count_nxt;
  logic [CNT_W-1:0]   stall_q;
  logic [FLUSH_W-1:0] flush_q;

  logic load_use;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush, mc_done;

  // load in EX whose destination feeds the instruction in ID; $0 never creates a dependency
  assign load_use = bus.idex_mem_read && (bus.idex_rt != 5'd0) &&
                    ((bus.idex_rt == bus.ifid_rs) ||
                     (bus.ifid_uses_rt && (bus.idex_rt == bus.ifid_rt)));

  // next state and Mealy stage controls; priority is multi-cycle > load-use > branch
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mc_done     = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      state_nxt  = RUN;
      count_nxt  = '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.mc_start && MC_STALLS) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
            count_nxt   = RELOAD;
            state_nxt   = MC_WAIT;
          end else begin
            // single-cycle "multi-cycle" op completes immediately without holding anything
            if (bus.mc_start) mc_done = 1'b1;
            if (load_use) begin
              pc_write   = 1'b0;
              ifid_write = 1'b0;
              idex_flush = 1'b1;
            end else if (bus.branch_taken) begin
              ifid_flush = 1'b1;
            end
          end
        end
        MC_WAIT: begin
          if (count != '0) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
            count_nxt   = count - 1'b1;
          end else begin
            mc_done   = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // FSM state and multi-cycle countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // saturating stall-cycle and IF/ID flush counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_write   = idex_write;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.mc_done      = mc_done;
  assign bus.busy         = (state == MC_WAIT) && !rst;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl: three builds (latency 4, latency 1, 4-bit stall counter).
// Latency: one record per cycle, checked on the falling edge of the cycle it was driven in.
// Backpressure: none; the monitor drains the queue every falling edge.
module tb_hazard_stall_ctrl;

  // output vector order: pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush, mc_done, busy
  localparam logic [7:0] RST = 8'b0000_0000;
  localparam logic [7:0] DEF = 8'b1101_0000;
  localparam logic [7:0] LU  = 8'b0001_1000;
  localparam logic [7:0] MCH = 8'b0000_0100;
  localparam logic [7:0] MCW = 8'b0000_0101;
  localparam logic [7:0] REL = 8'b1101_0011;
  localparam logic [7:0] BR  = 8'b1111_0000;
  localparam logic [7:0] MCD = 8'b1101_0010;

  typedef struct {
    int         id;
    int         step;
    logic [7:0] e;
    int         sc;
    int         fc;
  } exp_t;

  exp_t sb[$];
  int   nstep  = 0;
  int   checks = 0;
  int   errors = 0;

  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(32), .FLUSH_W(16)) if0 ();
  hazard_stall_ctrl_if #(.CNT_W(32), .FLUSH_W(16)) if1 ();
  hazard_stall_ctrl_if #(.CNT_W(4),  .FLUSH_W(16)) if2 ();

  hazard_stall_ctrl #(.MC_LATENCY(4), .CNT_W(32), .FLUSH_W(16)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  hazard_stall_ctrl #(.MC_LATENCY(1), .CNT_W(32), .FLUSH_W(16)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
  hazard_stall_ctrl #(.MC_LATENCY(4), .CNT_W(4),  .FLUSH_W(16)) dut2 (.clk(clk), .rst(rst2), .bus(if2));

  task automatic put(input int id, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                     input logic mr, input logic [4:0] xrt, input logic mcs, input logic br);
    case (id)
      0: begin
        if0.ifid_rs = rs; if0.ifid_rt = rt; if0.ifid_uses_rt = ur; if0.idex_mem_read = mr;
        if0.idex_rt = xrt; if0.mc_start = mcs; if0.branch_taken = br;
      end
      1: begin
        if1.ifid_rs = rs; if1.ifid_rt = rt; if1.ifid_uses_rt = ur; if1.idex_mem_read = mr;
        if1.idex_rt = xrt; if1.mc_start = mcs; if1.branch_taken = br;
      end
      default: begin
        if2.ifid_rs = rs; if2.ifid_rt = rt; if2.ifid_uses_rt = ur; if2.idex_mem_read = mr;
        if2.idex_rt = xrt; if2.mc_start = mcs; if2.branch_taken = br;
      end
    endcase
  endtask

  // drive one cycle on one build (others idle) and queue the hand-computed response;
  // sc/fc are the counter values accumulated over this build's earlier cycles
  task automatic step(input int id, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic mr, input logic [4:0] xrt, input logic mcs,
                      input logic br, input logic [7:0] e, input int sc, input int fc);
    exp_t x;
    @(posedge clk);
    #1;
    case (id)
      0:       rst0 = r;
      1:       rst1 = r;
      default: rst2 = r;
    endcase
    for (int k = 0; k < 3; k++) put(k, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    put(id, rs, rt, ur, mr, xrt, mcs, br);
    x.id = id; x.step = nstep; x.e = e; x.sc = sc; x.fc = fc;
    sb.push_back(x);
    nstep++;
  endtask

  task automatic idle(input int id, input logic r, input logic [7:0] e, input int sc, input int fc);
    step(id, r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, e, sc, fc);
  endtask

  // monitor: every falling edge, compare the DUT named by the oldest record
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t       r;
      logic [7:0] act;
      logic [31:0] asc;
      logic [31:0] afc;
      r = sb.pop_front();
      case (r.id)
        0: begin
          act = {if0.pc_write, if0.ifid_write, if0.ifid_flush, if0.idex_write,
                 if0.idex_flush, if0.exmem_flush, if0.mc_done, if0.busy};
          asc = if0.stall_cycles;
          afc = 32'(if0.flush_count);
        end
        1: begin
          act = {if1.pc_write, if1.ifid_write, if1.ifid_flush, if1.idex_write,
                 if1.idex_flush, if1.exmem_flush, if1.mc_done, if1.busy};
          asc = if1.stall_cycles;
          afc = 32'(if1.flush_count);
        end
        default: begin
          act = {if2.pc_write, if2.ifid_write, if2.ifid_flush, if2.idex_write,
                 if2.idex_flush, if2.exmem_flush, if2.mc_done, if2.busy};
          asc = 32'(if2.stall_cycles);
          afc = 32'(if2.flush_count);
        end
      endcase
      checks++;
      if (act !== r.e) begin
        errors++;
        $display("FAIL d%0d s%0d outs: got %b want %b", r.id, r.step, act, r.e);
      end
      checks++;
      if (asc !== 32'(r.sc)) begin
        errors++;
        $display("FAIL d%0d s%0d stall_cycles: got %0d want %0d", r.id, r.step, asc, r.sc);
      end
      checks++;
      if (afc !== 32'(r.fc)) begin
        errors++;
        $display("FAIL d%0d s%0d flush_count: got %0d want %0d", r.id, r.step, afc, r.fc);
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) put(k, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    // ---- latency-4 build ----
    idle(0, 1'b1, RST, 0, 0);
    idle(0, 1'b0, DEF, 0, 0);
    // load into $8, ID reads $8 as rs: one-cycle bubble
    step(0, 1'b0, 5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, LU, 0, 0);
    idle(0, 1'b0, DEF, 1, 0);
    // load to $0 never stalls
    step(0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, DEF, 1, 0);
    // rt match only counts when rt is a source
    step(0, 1'b0, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, DEF, 1, 0);
    step(0, 1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, LU, 1, 0);
    idle(0, 1'b0, DEF, 2, 0);
    // branch together with load-use: stall wins, no squash
    step(0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, LU, 2, 0);
    // branch alone
    step(0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, BR, 3, 0);
    idle(0, 1'b0, DEF, 3, 1);
    // multi-cycle op, MC_Start held: 3 hold cycles then release with MC_Done
    for (int i = 0; i < 4; i++)
      step(0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0,
           (i == 0) ? MCH : ((i == 3) ? REL : MCW), 3 + i, 1);
    idle(0, 1'b0, DEF, 6, 1);
    // hazards and branches are ignored inside MC_WAIT
    step(0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MCH, 6, 1);
    step(0, 1'b0, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1, MCW, 7, 1);
    step(0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, MCW, 8, 1);
    idle(0, 1'b0, REL, 9, 1);
    idle(0, 1'b0, DEF, 9, 1);
    // reset in the second MC_WAIT cycle aborts without MC_Done
    step(0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MCH, 9, 1);
    idle(0, 1'b0, MCW, 10, 1);
    idle(0, 1'b1, RST, 11, 1);
    idle(0, 1'b0, DEF, 0, 0);
    idle(0, 1'b0, DEF, 0, 0);
    // multi-cycle beats load-use and branch in RUN
    step(0, 1'b0, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, MCH, 0, 0);
    idle(0, 1'b0, MCW, 1, 0);
    idle(0, 1'b0, MCW, 2, 0);
    idle(0, 1'b0, REL, 3, 0);
    idle(0, 1'b0, DEF, 3, 0);

    // ---- latency-1 build: MC_Start never stalls ----
    idle(1, 1'b0, DEF, 0, 0);
    step(1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MCD, 0, 0);
    step(1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, MCD, 0, 0);
    idle(1, 1'b0, DEF, 0, 0);
    step(1, 1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, LU, 0, 0);
    idle(1, 1'b0, DEF, 1, 0);

    // ---- 4-bit stall counter build: saturates at 15 ----
    for (int i = 0; i < 20; i++)
      step(2, 1'b0, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, LU, (i > 15) ? 15 : i, 0);
    idle(2, 1'b0, DEF, 15, 0);
    idle(2, 1'b0, DEF, 15, 0);

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending records want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
